// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, gain term table and state type
package cordic_pkg;

  localparam int CORDIC_W = 32;

  // Q2.30 fixed-point unity
  localparam logic [31:0] Q2_30_ONE = 32'h4000_0000;

  // CSD decomposition of K ~= 0.6072529: sum over k of (+/-) 2^-SH[k]
  localparam logic [4:0] GAIN_SH [0:7] = '{5'd1, 5'd3, 5'd6, 5'd9, 5'd13, 5'd15, 5'd16, 5'd20};

  // bit k set means term k is subtracted
  localparam logic [7:0] GAIN_SUB = 8'b1111_1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic [4:0] gain_sh(input logic [2:0] k);
    return GAIN_SH[k];
  endfunction

  function automatic logic gain_sub(input logic [2:0] k);
    return GAIN_SUB[k];
  endfunction

endpackage

// File: rtl/cordic_gain_comp_if.sv
// rtl/cordic_gain_comp_if.sv - input/output handshake bundle of the gain compensation stage
interface cordic_gain_comp_if #(
  parameter int W = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [W-1:0] z_in;
  logic         neg_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x_out;
  logic [W-1:0] y_out;
  logic [W-1:0] z_out;

  // upstream/downstream side
  modport master (
    output in_valid, x_in, y_in, z_in, neg_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out
  );

  // gain compensation block side
  modport slave (
    input  in_valid, x_in, y_in, z_in, neg_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out
  );

endinterface

// File: rtl/cordic_gain_comp_csd_term_acc.sv
// rtl/cordic_gain_comp_csd_term_acc.sv - one channel of the CSD shift-add gain multiplier
module csd_term_acc
  import cordic_pkg::*;
#(
  parameter int W  = 32,
  parameter int AW = W + 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [2:0]   k,
  input  logic [W-1:0] din,
  output logic [W-1:0] res
);

  logic        [W-1:0]  cap;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] term;
  logic signed [AW-1:0] acc_nxt;

  // arithmetic shift keeps the sign, so truncation rounds toward -inf
  always_comb begin
    term    = $signed({{(AW - W){cap[W-1]}}, cap}) >>> gain_sh(k);
    acc_nxt = gain_sub(k) ? (acc - term) : (acc + term);
    res     = acc_nxt[W-1:0];
  end

  // capture the operand on accept, then accumulate one term per MUL cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap <= '0;
      acc <= '0;
    end else if (clear) begin
      cap <= din;
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/cordic_gain_comp.sv
// rtl/cordic_gain_comp.sv - removes CORDIC gain from (x, y) with an 8-cycle CSD multiply
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int W  = CORDIC_W,
  parameter int AW = W + 2
) (
  input  logic               clk,
  input  logic               rst_n,
  cordic_gain_comp_if.slave  bus
);

  state_t       state;
  logic [2:0]   k;
  logic         neg_cap;
  logic [W-1:0] z_cap;
  logic [W-1:0] x_res;
  logic [W-1:0] y_res;
  logic         out_valid_r;
  logic [W-1:0] x_out_r;
  logic [W-1:0] y_out_r;
  logic [W-1:0] z_out_r;
  logic         accept;
  logic         mul_en;

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.x_out     = x_out_r;
  assign bus.y_out     = y_out_r;
  assign bus.z_out     = z_out_r;

  assign accept = (state == ST_IDLE) && bus.in_valid;
  assign mul_en = (state == ST_MUL);

  csd_term_acc #(.W(W), .AW(AW)) u_acc_x (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .en    (mul_en),
    .k     (k),
    .din   (bus.x_in),
    .res   (x_res)
  );

  csd_term_acc #(.W(W), .AW(AW)) u_acc_y (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .en    (mul_en),
    .k     (k),
    .din   (bus.y_in),
    .res   (y_res)
  );

  // control FSM: accept in IDLE, 8 term cycles, then hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      k           <= 3'd0;
      neg_cap     <= 1'b0;
      z_cap       <= '0;
      out_valid_r <= 1'b0;
      x_out_r     <= '0;
      y_out_r     <= '0;
      z_out_r     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state   <= ST_MUL;
            k       <= 3'd0;
            neg_cap <= bus.neg_in;
            z_cap   <= bus.z_in;
          end
        end
        ST_MUL: begin
          k <= k + 3'd1;
          if (k == 3'd7) begin
            // |K*x| stays below 0.61 full scale, so negation cannot overflow
            x_out_r     <= neg_cap ? (~x_res + 1'b1) : x_res;
            y_out_r     <= neg_cap ? (~y_res + 1'b1) : y_res;
            z_out_r     <= z_cap;
            out_valid_r <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// tb/tb_cordic_gain_comp.sv - self-checking bench for cordic_gain_comp
module tb_cordic_gain_comp;

  // CSD gain value: 1/2 + 1/8 - 1/64 - 1/512 - 1/8192 - 1/32768 - 1/65536 - 1/1048576
  localparam real KC = 0.60725307464599609375;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  cordic_gain_comp_if #(.W(32)) bus ();

  cordic_gain_comp #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real ref_gain(input logic [31:0] v, input logic n);
    real r;
    r = KC * $itor($signed(v));
    return n ? -r : r;
  endfunction

  function automatic bit near(input logic [31:0] got, input real exp);
    real d;
    d = $itor($signed(got)) - $floor(exp + 0.5);
    if (d < 0.0) d = -d;
    return d <= 8.0;
  endfunction

  // one transaction; leaves the result held (out_ready low)
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input logic n, output logic [31:0] xo, output logic [31:0] yo,
                        output logic [31:0] zo, output int lat, output bit tmo);
    int w;
    @(negedge clk);
    bus.x_in = x; bus.y_in = y; bus.z_in = z; bus.neg_in = n;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(negedge clk); lat++; end
    xo = bus.x_out; yo = bus.y_out; zo = bus.z_out;
    tmo = (w >= 50) || (lat >= 50);
  endtask

  task automatic release_op();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int w;
    rst_n = 1'b0;
    bus.in_valid = 1'b1; bus.x_in = 32'h4000_0000; bus.y_in = 32'h0;
    bus.z_in = 32'h1234_5678; bus.neg_in = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.x_out !== 32'h0 || bus.y_out !== 32'h0 || bus.z_out !== 32'h0 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_values: x=%h y=%h z=%h ov=%b ir=%b expected 0 0 0 0 1",
               bus.x_out, bus.y_out, bus.z_out, bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL accept_after_reset: in_ready=%b expected 0", bus.in_ready);
    end
    w = 0;
    while (!bus.out_valid && w < 20) begin @(negedge clk); w++; end
    total++;
    if (bus.x_out !== 32'h26DD_3C00 || bus.z_out !== 32'h1234_5678) begin
      bad++;
      $display("FAIL first_result: x=%h z=%h expected 26dd3c00 12345678", bus.x_out, bus.z_out);
    end
    release_op();
  endtask

  task automatic test_vectors();
    logic [31:0] tx [3];
    logic [31:0] ty [3];
    logic        tn [3];
    logic [31:0] ex [3];
    logic [31:0] ey [3];
    logic [31:0] xo, yo, zo, zi;
    int lat;
    bit tmo;
    tx = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000};
    ty = '{32'h0,         32'h4000_0000, 32'h0};
    tn = '{1'b0,          1'b0,          1'b1};
    ex = '{32'h26DD_3C00, 32'hD922_C400, 32'hD922_C400};
    ey = '{32'h0,         32'h26DD_3C00, 32'h0};
    for (int i = 0; i < 3; i++) begin
      zi = $urandom;
      run_op(tx[i], ty[i], zi, tn[i], xo, yo, zo, lat, tmo);
      total++;
      if (tmo || xo !== ex[i] || yo !== ey[i] || zo !== zi) begin
        bad++;
        $display("FAIL vector%0d: x=%h y=%h z=%h tmo=%b expected %h %h %h", i, xo, yo, zo, tmo,
                 ex[i], ey[i], zi);
      end
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL latency%0d: got %0d expected 8", i, lat);
      end
      release_op();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] xo, yo, zo;
    int lat;
    bit tmo;
    int errs;
    run_op(32'h3000_0000, 32'hE000_0000, 32'hA5A5_5A5A, 1'b0, xo, yo, zo, lat, tmo);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      bus.x_in = $urandom; bus.y_in = $urandom; bus.z_in = $urandom;
      bus.neg_in = 1'($urandom); bus.in_valid = 1'($urandom);
      @(negedge clk);
      if (bus.x_out !== xo || bus.y_out !== yo || bus.z_out !== 32'hA5A5_5A5A ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) errs++;
    end
    total++;
    if (tmo || errs != 0) begin
      bad++;
      $display("FAIL hold_stable: %0d unstable cycles tmo=%b expected 0", errs, tmo);
    end
    total++;
    if (!near(xo, ref_gain(32'h3000_0000, 1'b0)) || !near(yo, ref_gain(32'hE000_0000, 1'b0))) begin
      bad++;
      $display("FAIL hold_value: x=%h y=%h not within 8 LSB of K*input", xo, yo);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL handshake: out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] xo, yo, zo;
    int lat;
    bit tmo;
    int seen;
    @(negedge clk);
    bus.x_in = 32'h4000_0000; bus.y_in = 32'h4000_0000; bus.z_in = 32'h0BAD_F00D;
    bus.neg_in = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.x_out !== 32'h0 || bus.y_out !== 32'h0 || bus.z_out !== 32'h0 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: x=%h y=%h z=%h ov=%b ir=%b expected 0 0 0 0 1",
               bus.x_out, bus.y_out, bus.z_out, bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_discard: out_valid seen %0d times expected 0", seen);
    end
    run_op(32'hC000_0000, 32'h4000_0000, 32'h7777_0000, 1'b1, xo, yo, zo, lat, tmo);
    total++;
    if (tmo || lat != 8 || xo !== 32'h26DD_3C00 || yo !== 32'hD922_C400 || zo !== 32'h7777_0000) begin
      bad++;
      $display("FAIL after_reset: x=%h y=%h z=%h lat=%0d expected 26dd3c00 d922c400 77770000 8",
               xo, yo, zo, lat);
    end
    release_op();
  endtask

  task automatic test_back_to_back();
    logic [31:0] qx [$];
    logic [31:0] qy [$];
    logic [31:0] qz [$];
    logic        qn [$];
    logic [31:0] ex, ey, ez;
    logic        en;
    int sent, got, last, errs, perr;
    sent = 0; got = 0; last = -1; errs = 0; perr = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 300 && got < 12; c++) begin
      if (bus.out_valid) begin
        if (qx.size() == 0) errs++;
        else begin
          ex = qx.pop_front(); ey = qy.pop_front(); ez = qz.pop_front(); en = qn.pop_front();
          if (!near(bus.x_out, ref_gain(ex, en)) || !near(bus.y_out, ref_gain(ey, en)) ||
              bus.z_out !== ez) begin
            errs++;
            $display("FAIL b2b_value: x_in=%h y_in=%h neg=%b got x=%h y=%h z=%h", ex, ey, en,
                     bus.x_out, bus.y_out, bus.z_out);
          end
        end
        if (last >= 0 && cyc - last != 10) perr++;
        last = cyc;
        got++;
      end
      if (bus.in_ready && sent < 12) begin
        bus.x_in = $urandom; bus.y_in = $urandom; bus.z_in = $urandom;
        bus.neg_in = 1'($urandom); bus.in_valid = 1'b1;
        qx.push_back(bus.x_in); qy.push_back(bus.y_in);
        qz.push_back(bus.z_in); qn.push_back(bus.neg_in);
        sent++;
      end else if (sent >= 12) begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    total++;
    if (errs != 0 || got != 12) begin
      bad++;
      $display("FAIL b2b_results: %0d wrong, %0d of 12 received", errs, got);
    end
    total++;
    if (perr != 0) begin
      bad++;
      $display("FAIL b2b_throughput: %0d intervals differ from 10 cycles", perr);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.neg_in = 1'b0;
    bus.x_in = '0; bus.y_in = '0; bus.z_in = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
